// File: rtl/filter_window_controller_pkg.sv
// Shared definitions for the frame-level 3x3 window controller.
package filter_window_controller_pkg;

  localparam int PIXEL_WIDTH  = 8;
  localparam int COLUMN_WIDTH = 3 * PIXEL_WIDTH;
  localparam int WINDOW_WIDTH = 9 * PIXEL_WIDTH;

  typedef enum logic [2:0] {
    FWC_IDLE  = 3'd0,
    FWC_PRIME = 3'd1,
    FWC_FETCH = 3'd2,
    FWC_WRITE = 3'd3,
    FWC_DONE  = 3'd4
  } fwc_state_t;

  // Window row addressed by the read issued at step idx (reads go top,
  // middle, bottom, then repeat for the next column).
  function automatic logic [1:0] read_row(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd3: read_row = 2'd0;
      3'd1, 3'd4: read_row = 2'd1;
      default:    read_row = 2'd2;
    endcase
  endfunction

  // Window row whose data returns at step idx (one cycle behind the read).
  function automatic logic [1:0] capture_row(input logic [2:0] idx);
    case (idx)
      3'd1, 3'd4: capture_row = 2'd0;
      3'd2, 3'd5: capture_row = 2'd1;
      default:    capture_row = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/filter_window_controller_window.sv
// 3x3 pixel window held as three columns; new columns enter on the right.
module window_shift_register
  import filter_window_controller_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        col_valid,
  input  logic [23:0] col_in,
  output logic [71:0] pixel_values
);

  logic [2:0][COLUMN_WIDTH-1:0] cols;

  // Shift the window one column left whenever a full column has arrived.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cols <= '0;
    end else if (col_valid) begin
      cols[0] <= cols[1];
      cols[1] <= cols[2];
      cols[2] <= col_in;
    end
  end

  // Flatten to the filter ordering: pixel k = 3*row + col.
  always_comb begin
    pixel_values = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        pixel_values[PIXEL_WIDTH*(3*r+c) +: PIXEL_WIDTH] = cols[c][PIXEL_WIDTH*r +: PIXEL_WIDTH];
      end
    end
  end

endmodule

// File: rtl/filter_window_controller.sv
// Walks every interior pixel of a frame, builds its 3x3 window from the
// source memory and writes the filter result to the destination memory.
//
// state | meaning
// IDLE  | waiting for start, counters cleared
// PRIME | fetch columns 0 and 1 of the three rows around y (6 reads, 7 cycles)
// FETCH | fetch column cx of the three rows (3 reads, 4 cycles)
// WRITE | write filter result for centre (cx-1, y)
// DONE  | one-cycle completion pulse
module filter_window_controller
  import filter_window_controller_pkg::*;
#(
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 120,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [7:0]            rd_data,
  output logic [71:0]           pixel_values,
  input  logic [7:0]            filter_result,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data
);

  localparam logic [ADDR_WIDTH-1:0] ROW_STEP  = ADDR_WIDTH'(IMG_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP2 = ADDR_WIDTH'(2 * IMG_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] CX_LAST   = ADDR_WIDTH'(IMG_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] Y_LAST    = ADDR_WIDTH'(IMG_HEIGHT - 2);

  fwc_state_t            state, state_nxt;
  logic [2:0]            idx, idx_nxt;
  logic [ADDR_WIDTH-1:0] cx, cx_nxt;
  logic [ADDR_WIDTH-1:0] y, y_nxt;
  // base holds (y-1)*IMG_WIDTH, the address of the top window row.
  logic [ADDR_WIDTH-1:0] base, base_nxt;
  logic [1:0]            rd_row;
  logic [ADDR_WIDTH-1:0] rd_col;
  logic [ADDR_WIDTH-1:0] row_base;
  logic                  cap_en;
  logic [1:0]            cap_row;
  logic [15:0]           col_buf;
  logic                  col_valid;
  logic [23:0]           col_in;

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FWC_IDLE;
      idx   <= '0;
      cx    <= '0;
      y     <= '0;
      base  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cx    <= cx_nxt;
      y     <= y_nxt;
      base  <= base_nxt;
    end
  end

  // Next-state, counter updates and per-state strobes.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cx_nxt    = cx;
    y_nxt     = y;
    base_nxt  = base;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    rd_row    = 2'd0;
    rd_col    = '0;
    wr_en     = 1'b0;
    cap_en    = 1'b0;
    case (state)
      FWC_IDLE: begin
        idx_nxt  = '0;
        cx_nxt   = '0;
        y_nxt    = '0;
        base_nxt = '0;
        if (start) begin
          state_nxt = FWC_PRIME;
          y_nxt     = ADDR_WIDTH'(1);
        end
      end
      FWC_PRIME: begin
        busy   = 1'b1;
        rd_en  = (idx < 3'd6);
        rd_row = read_row(idx);
        rd_col = (idx < 3'd3) ? '0 : ADDR_WIDTH'(1);
        cap_en = (idx != 3'd0);
        if (idx == 3'd6) begin
          state_nxt = FWC_FETCH;
          idx_nxt   = '0;
          cx_nxt    = ADDR_WIDTH'(2);
        end else begin
          idx_nxt = idx + 3'd1;
        end
      end
      FWC_FETCH: begin
        busy   = 1'b1;
        rd_en  = (idx < 3'd3);
        rd_row = read_row(idx);
        rd_col = cx;
        cap_en = (idx != 3'd0);
        if (idx == 3'd3) begin
          state_nxt = FWC_WRITE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 3'd1;
        end
      end
      FWC_WRITE: begin
        busy  = 1'b1;
        wr_en = 1'b1;
        if (cx < CX_LAST) begin
          cx_nxt    = cx + ADDR_WIDTH'(1);
          state_nxt = FWC_FETCH;
        end else if (y < Y_LAST) begin
          y_nxt     = y + ADDR_WIDTH'(1);
          base_nxt  = base + ROW_STEP;
          cx_nxt    = '0;
          state_nxt = FWC_PRIME;
        end else begin
          state_nxt = FWC_DONE;
        end
      end
      FWC_DONE: begin
        done      = 1'b1;
        state_nxt = FWC_IDLE;
      end
      default: state_nxt = FWC_IDLE;
    endcase
  end

  // Read and write addresses; both are held at zero when their strobe is low.
  always_comb begin
    case (rd_row)
      2'd1:    row_base = base + ROW_STEP;
      2'd2:    row_base = base + ROW_STEP2;
      default: row_base = base;
    endcase
    rd_addr = rd_en ? (row_base + rd_col) : '0;
    wr_addr = wr_en ? (base + ROW_STEP + cx - ADDR_WIDTH'(1)) : '0;
    wr_data = wr_en ? filter_result : '0;
  end

  // Column assembler: hold the top and middle returns until the bottom arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_buf <= '0;
    end else if (cap_en) begin
      if (cap_row == 2'd0) col_buf[7:0]  <= rd_data;
      if (cap_row == 2'd1) col_buf[15:8] <= rd_data;
    end
  end

  assign cap_row   = capture_row(idx);
  assign col_valid = cap_en && (cap_row == 2'd2);
  assign col_in    = {rd_data, col_buf};

  window_shift_register u_window (
    .clk          (clk),
    .reset        (reset),
    .col_valid    (col_valid),
    .col_in       (col_in),
    .pixel_values (pixel_values)
  );

endmodule

// File: tb/tb_filter_window_controller.sv
// Bench for filter_window_controller: a 5x4 and a 3x3 instance, each with a
// 256-entry source memory model and a centre-pixel "filter".
module tb_filter_window_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // ---------------- DUT A: 5x4 ----------------
  logic        a_reset, a_start, a_busy, a_done, a_rd_en, a_wr_en;
  logic [7:0]  a_rd_addr, a_rd_data, a_filt, a_wr_addr, a_wr_data;
  logic [71:0] a_pix;
  logic [7:0]  a_mem [256];

  filter_window_controller #(.IMG_WIDTH(5), .IMG_HEIGHT(4), .ADDR_WIDTH(8)) dut_a (
    .clk(clk), .reset(a_reset), .start(a_start), .busy(a_busy), .done(a_done),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .pixel_values(a_pix), .filter_result(a_filt),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data)
  );
  assign a_filt = a_pix[39:32];
  always @(posedge clk) if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];

  // ---------------- DUT B: 3x3 ----------------
  logic        b_reset, b_start, b_busy, b_done, b_rd_en, b_wr_en;
  logic [7:0]  b_rd_addr, b_rd_data, b_filt, b_wr_addr, b_wr_data;
  logic [71:0] b_pix;
  logic [7:0]  b_mem [256];

  filter_window_controller #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .ADDR_WIDTH(8)) dut_b (
    .clk(clk), .reset(b_reset), .start(b_start), .busy(b_busy), .done(b_done),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .pixel_values(b_pix), .filter_result(b_filt),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data)
  );
  assign b_filt = b_pix[39:32];
  always @(posedge clk) if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];

  // ---------------- monitors (free-running counters, never cleared) -------
  int a_busy_cnt = 0, a_done_cnt = 0, a_overlap = 0, a_rise_at = 0, a_done_at = 0;
  logic a_busy_d = 1'b0;
  logic [7:0]  a_waddr_q [$];
  logic [7:0]  a_wdata_q [$];
  logic [71:0] a_wpix_q  [$];

  always @(negedge clk) begin
    if (a_busy) a_busy_cnt++;
    if (a_busy && !a_busy_d) a_rise_at = cyc;
    a_busy_d = a_busy;
    if (a_done) begin a_done_cnt++; a_done_at = cyc; end
    if (a_rd_en && a_wr_en) a_overlap++;
    if (a_wr_en) begin
      a_waddr_q.push_back(a_wr_addr);
      a_wdata_q.push_back(a_wr_data);
      a_wpix_q.push_back(a_pix);
    end
  end

  int b_busy_cnt = 0, b_done_cnt = 0, b_overlap = 0;
  logic [7:0]  b_waddr_q [$];
  logic [7:0]  b_wdata_q [$];
  logic [71:0] b_wpix_q  [$];

  always @(negedge clk) begin
    if (b_busy) b_busy_cnt++;
    if (b_done) b_done_cnt++;
    if (b_rd_en && b_wr_en) b_overlap++;
    if (b_wr_en) begin
      b_waddr_q.push_back(b_wr_addr);
      b_wdata_q.push_back(b_wr_data);
      b_wpix_q.push_back(b_pix);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start_a();
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
  endtask

  task automatic pulse_start_b();
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    int k = 0;
    while (!a_done && k < budget) begin @(negedge clk); k++; end
    if (!a_done) begin
      total++; bad++;
      $display("FAIL wait_done_a timeout after %0d cycles", budget);
    end
  endtask

  task automatic wait_done_b(input int budget);
    int k = 0;
    while (!b_done && k < budget) begin @(negedge clk); k++; end
    if (!b_done) begin
      total++; bad++;
      $display("FAIL wait_done_b timeout after %0d cycles", budget);
    end
  endtask

  // Reference model: every interior pixel in raster order, written with the
  // centre value, while the filter sees the 3x3 neighbourhood from memory.
  task automatic check_frame(input string tag, input int W, input int H,
                             input logic [7:0] mem [256],
                             input logic [7:0] aq [$], input logic [7:0] dq [$],
                             input logic [71:0] pq [$], input int off);
    int n;
    int nb;
    n = (W - 2) * (H - 2);
    check($sformatf("%s_count", tag), aq.size() - off, n);
    for (int i = 0; i < n; i++) begin
      if (off + i < aq.size()) begin
        int y, x, a;
        logic [71:0] w;
        y = 1 + i / (W - 2);
        x = 1 + i % (W - 2);
        a = y * W + x;
        w = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            w[8*(3*r+c) +: 8] = mem[(y - 1 + r) * W + (x - 1 + c)];
        check($sformatf("%s_addr%0d", tag, i), aq[off+i], a);
        check($sformatf("%s_data%0d", tag, i), dq[off+i], mem[a]);
        check($sformatf("%s_win%0d", tag, i), pq[off+i], w);
      end
    end
    nb = 0;
    for (int i = off; i < aq.size(); i++) begin
      int x, y;
      x = aq[i] % W;
      y = aq[i] / W;
      if (x == 0 || x == W - 1 || y == 0 || y == H - 1) nb++;
    end
    check($sformatf("%s_border_writes", tag), nb, 0);
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_vec_t;

  wr_vec_t    small_tab [6];
  logic [7:0] win_tab   [9];

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_busy, s_done, s_wr, d_cyc;

    small_tab[0] = '{8'd6,  8'd6};
    small_tab[1] = '{8'd7,  8'd7};
    small_tab[2] = '{8'd8,  8'd8};
    small_tab[3] = '{8'd11, 8'd11};
    small_tab[4] = '{8'd12, 8'd12};
    small_tab[5] = '{8'd13, 8'd13};
    win_tab = '{8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12};

    a_reset = 1'b1; b_reset = 1'b1; a_start = 1'b0; b_start = 1'b0;
    for (int i = 0; i < 256; i++) begin a_mem[i] = 8'(i); b_mem[i] = 8'hA5; end

    // Reset values
    repeat (2) @(negedge clk);
    check("reset_outputs_a",
          {a_busy, a_done, a_rd_en, a_wr_en, a_rd_addr, a_wr_addr, a_wr_data, a_pix}, '0);
    check("reset_outputs_b",
          {b_busy, b_done, b_rd_en, b_wr_en, b_rd_addr, b_wr_addr, b_wr_data, b_pix}, '0);
    a_reset = 1'b0; b_reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_outputs_a", {a_busy, a_done, a_rd_en, a_wr_en}, '0);

    // Small frame, src[a]=a
    s_busy = a_busy_cnt; s_done = a_done_cnt; s_wr = a_waddr_q.size();
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    check("first_cycle_busy_rd", {a_busy, a_rd_en, a_rd_addr}, {1'b1, 1'b1, 8'd0});
    wait_done_a(200);
    repeat (3) @(negedge clk);
    check("small_busy_cycles", a_busy_cnt - s_busy, 44);
    check("small_done_pulses", a_done_cnt - s_done, 1);
    check("small_done_timing", a_done_at - a_rise_at, 44);
    check("small_write_count", a_waddr_q.size() - s_wr, 6);
    for (int i = 0; i < 6; i++) begin
      if (s_wr + i < a_waddr_q.size()) begin
        check($sformatf("small_addr%0d", i), a_waddr_q[s_wr+i], small_tab[i].addr);
        check($sformatf("small_data%0d", i), a_wdata_q[s_wr+i], small_tab[i].data);
      end
    end
    if (s_wr < a_wpix_q.size())
      for (int k = 0; k < 9; k++)
        check($sformatf("window_byte%0d", k), a_wpix_q[s_wr][8*k +: 8], win_tab[k]);
    check("small_overlap", a_overlap, 0);

    // Start re-pulsed mid-frame is ignored
    s_busy = a_busy_cnt; s_done = a_done_cnt; s_wr = a_waddr_q.size();
    pulse_start_a();
    repeat (20) @(negedge clk);
    a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    wait_done_a(200);
    repeat (3) @(negedge clk);
    check("restart_busy_cycles", a_busy_cnt - s_busy, 44);
    check("restart_done_pulses", a_done_cnt - s_done, 1);
    check("restart_done_timing", a_done_at - a_rise_at, 44);
    check("restart_write_count", a_waddr_q.size() - s_wr, 6);

    // Random source frames against the reference model
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 256; i++) a_mem[i] = 8'($urandom);
      s_busy = a_busy_cnt; s_wr = a_waddr_q.size();
      pulse_start_a();
      wait_done_a(200);
      repeat (2) @(negedge clk);
      check_frame($sformatf("rand%0d", t), 5, 4, a_mem, a_waddr_q, a_wdata_q, a_wpix_q, s_wr);
      check($sformatf("rand%0d_busy", t), a_busy_cnt - s_busy, 44);
    end

    // Minimum 3x3 frame
    s_busy = b_busy_cnt; s_done = b_done_cnt; s_wr = b_waddr_q.size();
    pulse_start_b();
    wait_done_b(100);
    repeat (3) @(negedge clk);
    check("min_busy_cycles", b_busy_cnt - s_busy, 12);
    check("min_done_pulses", b_done_cnt - s_done, 1);
    check("min_write_count", b_waddr_q.size() - s_wr, 1);
    if (s_wr < b_waddr_q.size()) begin
      check("min_addr", b_waddr_q[s_wr], 8'd4);
      check("min_data", b_wdata_q[s_wr], 8'hA5);
    end
    for (int i = 0; i < 256; i++) b_mem[i] = 8'($urandom);
    s_wr = b_waddr_q.size();
    pulse_start_b();
    wait_done_b(100);
    repeat (2) @(negedge clk);
    check_frame("min_rand", 3, 3, b_mem, b_waddr_q, b_wdata_q, b_wpix_q, s_wr);
    check("min_overlap", b_overlap, 0);

    // Reset during the third write
    for (int i = 0; i < 256; i++) a_mem[i] = 8'(i);
    s_done = a_done_cnt; s_wr = a_waddr_q.size();
    pulse_start_a();
    begin
      int nw, k;
      nw = 0; k = 0;
      if (a_wr_en) nw++;
      while (nw < 3 && k < 300) begin
        @(negedge clk); k++;
        if (a_wr_en) nw++;
      end
      check("reset_test_reached_write3", nw, 3);
    end
    #1 a_reset = 1'b1;
    #1;
    check("midreset_outputs",
          {a_busy, a_done, a_rd_en, a_wr_en, a_rd_addr, a_wr_addr, a_wr_data, a_pix}, '0);
    repeat (3) @(negedge clk);
    a_reset = 1'b0;
    repeat (8) @(negedge clk);
    check("midreset_writes_stopped", a_waddr_q.size() - s_wr, 3);
    check("midreset_no_done", a_done_cnt - s_done, 0);
    s_wr = a_waddr_q.size();
    pulse_start_a();
    wait_done_a(200);
    repeat (2) @(negedge clk);
    check_frame("after_reset", 5, 4, a_mem, a_waddr_q, a_wdata_q, a_wpix_q, s_wr);

    // Back-to-back frames with start held high
    s_busy = a_busy_cnt; s_done = a_done_cnt; s_wr = a_waddr_q.size();
    @(negedge clk); a_start = 1'b1;
    @(negedge clk);
    wait_done_a(200);
    d_cyc = cyc;
    @(negedge clk);
    check("b2b_idle_gap_busy", a_busy, 1'b0);
    @(negedge clk);
    check("b2b_second_frame_busy", {a_busy, a_rd_en}, 2'b11);
    a_start = 1'b0;
    wait_done_a(200);
    check("b2b_second_done_cycle", cyc - d_cyc, 46);
    repeat (3) @(negedge clk);
    check("b2b_write_count", a_waddr_q.size() - s_wr, 12);
    check("b2b_done_pulses", a_done_cnt - s_done, 2);
    check("b2b_busy_cycles", a_busy_cnt - s_busy, 88);
    check("b2b_overlap", a_overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
